// File: rtl/div_unit_if.sv
// div_unit_if -- execute-stage divider handshake bundle.
//
// Groups the request, operand, cancel and result signals exchanged between
// the pipeline (master) and the divider (slave). Clock and reset are plain
// ports on the divider itself.
//   start      : divide request, held high until the result is consumed
//   signed_div : 1 = signed DIV, 0 = unsigned DIVU
//   opdata1    : dividend
//   opdata2    : divisor
//   annul      : cancel from the flush/exception path
//   result     : {remainder -> HI, quotient -> LO}
//   ready      : result valid
//   stall_req  : busy indication to the hazard unit
interface div_unit_if;
  logic        start;
  logic        signed_div;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stall_req;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, stall_req
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, stall_req
  );
endinterface

// File: rtl/div_unit.sv
// div_unit -- 32-bit iterative restoring divider (DIV / DIVU).
//
// Ports:
//   clk    : single clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : div_unit_if.slave (start, signed_div, opdata1, opdata2, annul
//            in; result, ready, stall_req out)
//
// One quotient bit is produced per cycle on the operand magnitudes; signs
// are applied when the last bit is known, so the result register is only
// written on entry to DONE (or cleared by annul/reset). A zero divisor skips
// the iteration and reports an all-zero result one cycle after acceptance.
module div_unit (
  input logic       clk,
  input logic       resetn,
  div_unit_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  stateReg;
  logic [5:0]  cntReg;
  logic [31:0] divisorReg;
  logic [31:0] quotReg;     // holds the dividend magnitude, shifted out as quotient bits shift in
  logic [31:0] remReg;
  logic        negQuotReg;
  logic        negRemReg;
  logic [63:0] resultReg;

  logic [31:0] absDividend;
  logic [31:0] absDivisor;
  logic [32:0] remShift;
  logic        fits;
  logic [31:0] remDiff;
  logic [31:0] remNext;
  logic [31:0] quotNext;
  logic [31:0] finalQuot;
  logic [31:0] finalRem;
  logic        readyInt;

  // Negating 0x80000000 yields 0x80000000, which is exactly the unsigned
  // magnitude we want, so no special case is needed.
  assign absDividend = (bus.signed_div && bus.opdata1[31]) ? (~bus.opdata1 + 32'd1) : bus.opdata1;
  assign absDivisor  = (bus.signed_div && bus.opdata2[31]) ? (~bus.opdata2 + 32'd1) : bus.opdata2;

  // Restoring step: shift the next dividend bit into the partial remainder
  // and subtract the divisor when it fits. When it fits the true difference
  // is below the divisor, so the 32-bit modular difference is exact.
  assign remShift = {remReg, quotReg[31]};
  assign fits     = (remShift >= {1'b0, divisorReg});
  assign remDiff  = remShift[31:0] - divisorReg;
  assign remNext  = fits ? remDiff : remShift[31:0];
  assign quotNext = {quotReg[30:0], fits};

  assign finalQuot = negQuotReg ? (~quotNext + 32'd1) : quotNext;
  assign finalRem  = negRemReg  ? (~remNext  + 32'd1) : remNext;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stateReg   <= IDLE;
      cntReg     <= 6'd0;
      divisorReg <= 32'd0;
      quotReg    <= 32'd0;
      remReg     <= 32'd0;
      negQuotReg <= 1'b0;
      negRemReg  <= 1'b0;
      resultReg  <= 64'd0;
    end else if (bus.annul) begin
      stateReg  <= IDLE;
      cntReg    <= 6'd0;
      resultReg <= 64'd0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.start) begin
            if (bus.opdata2 == 32'd0) begin
              stateReg  <= DONE;
              resultReg <= 64'd0;
            end else begin
              stateReg   <= CALC;
              cntReg     <= 6'd0;
              divisorReg <= absDivisor;
              quotReg    <= absDividend;
              remReg     <= 32'd0;
              // Quotient is negative iff signs differ; remainder follows the dividend.
              negQuotReg <= bus.signed_div & (bus.opdata1[31] ^ bus.opdata2[31]);
              negRemReg  <= bus.signed_div & bus.opdata1[31];
            end
          end
        end
        CALC: begin
          remReg  <= remNext;
          quotReg <= quotNext;
          cntReg  <= cntReg + 6'd1;
          if (cntReg == 6'd31) begin
            stateReg  <= DONE;
            resultReg <= {finalRem, finalQuot};
          end
        end
        DONE: begin
          // Holding start keeps the result presented; no relaunch until it drops.
          if (!bus.start) begin
            stateReg <= IDLE;
          end
        end
        default: stateReg <= IDLE;
      endcase
    end
  end

  assign readyInt      = (stateReg == DONE);
  assign bus.ready     = readyInt;
  assign bus.result    = resultReg;
  assign bus.stall_req = bus.start & ~readyInt;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit -- self-checking bench for div_unit: table vectors, random
// divides against an arithmetic reference, and annul/reset sequences.
module tb_div_unit;

  logic clk;
  logic resetn;
  div_unit_if bus ();

  div_unit dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic (truncating division, remainder has
  // the dividend's sign), zero divisor gives zero.
  function automatic logic [63:0] refDiv(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
    end else begin
      sa = {32'd0, a};
      sb = {32'd0, b};
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Launch one divide, scramble the operands after acceptance, measure the
  // latency, check the result and its stability while start stays high.
  task automatic runDiv(input string name, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int lat, input int hold);
    int          got;
    logic        stallBad;
    logic [63:0] res;
    got      = -1;
    stallBad = 1'b0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    #1;
    if (bus.stall_req !== 1'b1 || bus.ready !== 1'b0) stallBad = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      bus.signed_div = 1'($urandom);
      bus.opdata1    = $urandom;
      bus.opdata2    = $urandom;
      #1;
      if (bus.ready === 1'b1) begin
        got = k;
        break;
      end
      if (bus.stall_req !== 1'b1) stallBad = 1'b1;
    end
    check({name, " latency"}, 64'(got), 64'(lat));
    check({name, " result"}, bus.result, exp);
    check({name, " stall"}, {63'd0, stallBad | bus.stall_req}, 64'd0);
    res = bus.result;
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      check({name, " hold"}, {bus.result[62:0], bus.ready}, {res[62:0], 1'b1});
    end
    bus.start = 1'b0;
    @(negedge clk);
    check({name, " idle"}, {63'd0, bus.ready}, 64'd0);
    $display("div %s sgn=%0d a=%h b=%h res=%h lat=%0d", name, sgn, a, b, res, got);
  endtask

  initial begin
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        sawReady;
    int          got;

    total = 0;
    bad   = 0;
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd0;
    bus.opdata2    = 32'd0;
    bus.annul      = 1'b0;

    vecs[0] = '{1'b0, 32'd100,        32'd7,        64'h00000002_0000000E, 33, 2};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h2,        64'hFFFFFFFF_FFFFFFFD, 33, 1};
    vecs[2] = '{1'b1, 32'h80000000,   32'hFFFFFFFF, 64'h00000000_80000000, 33, 1};
    vecs[3] = '{1'b0, 32'h80000000,   32'hFFFFFFFF, 64'h80000000_00000000, 33, 1};
    vecs[4] = '{1'b0, 32'd5,          32'd0,        64'h0,                 1,  3};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33, 1};
    vecs[6] = '{1'b0, 32'hFFFFFFFF,   32'd1,        64'h00000000_FFFFFFFF, 33, 1};
    vecs[7] = '{1'b0, 32'd3,          32'd10,       64'h00000003_00000000, 33, 1};
    vecs[8] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF, 64'h00000000_00000001, 33, 3};
    vecs[9] = '{1'b1, 32'hFFFFFFF9,   32'd0,        64'h0,                 1,  1};

    repeat (3) @(negedge clk);
    check("reset result", bus.result, 64'd0);
    check("reset ready/stall", {62'd0, bus.ready, bus.stall_req}, 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < 10; i++) begin
      runDiv($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, vecs[i].hold);
    end

    for (int i = 0; i < 25; i++) begin
      sgn = 1'($urandom);
      a   = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 15));
        1: b = ~32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      runDiv($sformatf("rnd%0d", i), sgn, a, b, refDiv(sgn, a, b), (b == 32'd0) ? 1 : 33, 1);
    end

    // Annul during CALC step 10; the previous result is nonzero so the clear is visible.
    runDiv("pre", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1);
    sawReady = 1'b0;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd1000;
    bus.opdata2    = 32'd3;
    repeat (10) begin
      @(negedge clk);
      if (bus.ready === 1'b1) sawReady = 1'b1;
    end
    bus.annul = 1'b1;
    @(negedge clk);
    bus.annul = 1'b0;
    bus.start = 1'b0;
    check("annul result", bus.result, 64'd0);
    repeat (3) begin
      if (bus.ready === 1'b1) sawReady = 1'b1;
      @(negedge clk);
    end
    check("annul ready", {63'd0, sawReady}, 64'd0);
    $display("annul seq result=%h", bus.result);
    runDiv("post_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 1);

    // Reset mid-CALC with start held through release.
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = 1'b1;
    bus.opdata1    = 32'hFFFFFFF9;
    bus.opdata2    = 32'h2;
    repeat (6) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("rst result", bus.result, 64'd0);
    check("rst ready", {63'd0, bus.ready}, 64'd0);
    resetn = 1'b1;
    got = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        got = k;
        break;
      end
    end
    check("rst relaunch latency", 64'(got), 64'd33);
    check("rst relaunch result", bus.result, 64'hFFFFFFFF_FFFFFFFD);
    $display("reset seq lat=%0d result=%h", got, bus.result);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
